// File: rtl/sc_clock_sequencer.sv
// rtl/sc_clock_sequencer.sv - four-phase clock sequencer with run/halt/step, PC breakpoint and retire counter
// Every output is a flop, so the phase clocks never glitch.
module sc_clock_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic             step,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_clock,
  output logic             imem_clock,
  output logic             dmem_clock,
  output logic             running,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic             first_q, first_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             imem_q, imem_d;
  logic             dmem_q, dmem_d;
  logic             cpu_q, cpu_d;
  logic             running_q, running_d;
  logic             bp_cond;

  // first masks the breakpoint for the instruction a resumed run starts on
  assign bp_cond = bp_en && (pc == bp_addr) && !first_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    first_d  = first_q;
    bp_hit_d = bp_hit_q;
    cnt_d    = cnt_q;

    if (ph_q == 2'd3) begin
      case (state_q)
        ST_HALT: begin
          if (run) begin
            state_d  = ST_RUN;
            ph_d     = 2'd0;
            first_d  = 1'b1;
            bp_hit_d = 1'b0;
          end else if (step) begin
            state_d  = ST_STEP;
            ph_d     = 2'd0;
            bp_hit_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_d = ST_HALT;
          end else if (bp_cond) begin
            state_d  = ST_HALT;
            bp_hit_d = 1'b1;
          end else begin
            ph_d = 2'd0;
          end
        end
        ST_STEP: state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase
    end else begin
      ph_d = ph_q + 2'd1;
      if (ph_q == 2'd1) begin
        cnt_d   = cnt_q + CNT_W'(1);
        first_d = 1'b0;
      end
    end

    // Outputs are decoded from the next phase so they line up with it once registered
    running_d = (state_d != ST_HALT);
    imem_d    = running_d && (ph_d == 2'd0);
    dmem_d    = running_d && (ph_d == 2'd1);
    cpu_d     = running_d && (ph_d == 2'd2);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_HALT;
      ph_q      <= 2'd3;
      first_q   <= 1'b0;
      bp_hit_q  <= 1'b0;
      cnt_q     <= '0;
      imem_q    <= 1'b0;
      dmem_q    <= 1'b0;
      cpu_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      first_q   <= first_d;
      bp_hit_q  <= bp_hit_d;
      cnt_q     <= cnt_d;
      imem_q    <= imem_d;
      dmem_q    <= dmem_d;
      cpu_q     <= cpu_d;
      running_q <= running_d;
    end
  end

  assign cpu_clock   = cpu_q;
  assign imem_clock  = imem_q;
  assign dmem_clock  = dmem_q;
  assign running     = running_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_sc_clock_sequencer.sv
// tb/tb_sc_clock_sequencer.sv - directed self-checking bench for sc_clock_sequencer
module tb_sc_clock_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        cpu_clock, imem_clock, dmem_clock, running, bp_hit;
  logic [31:0] instr_count;
  logic        cpu_clock4, imem_clock4, dmem_clock4, running4, bp_hit4;
  logic [3:0]  instr_count4;

  int checks = 0;
  int failures = 0;
  int ic, dc, cc, rc, overlap, order_err;
  logic prev_imem, prev_dmem;

  always #5 clock = ~clock;

  sc_clock_sequencer #(.CNT_W(32)) dut (
    .clock(clock), .resetn(resetn), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_clock(cpu_clock), .imem_clock(imem_clock),
    .dmem_clock(dmem_clock), .running(running), .bp_hit(bp_hit), .instr_count(instr_count)
  );

  sc_clock_sequencer #(.CNT_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .run(run), .step(step), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_clock(cpu_clock4), .imem_clock(imem_clock4),
    .dmem_clock(dmem_clock4), .running(running4), .bp_hit(bp_hit4), .instr_count(instr_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    ic = 0; dc = 0; cc = 0; rc = 0; overlap = 0; order_err = 0;
    prev_imem = 1'b0; prev_dmem = 1'b0;
  endtask

  // One master cycle; samples 1 ns after the edge and advances the modelled CPU PC on cpu_clock
  task automatic tick();
    @(posedge clock);
    #1;
    ic += int'(imem_clock);
    dc += int'(dmem_clock);
    cc += int'(cpu_clock);
    rc += int'(running);
    if ((int'(imem_clock) + int'(dmem_clock) + int'(cpu_clock)) > 1) overlap++;
    if ((dmem_clock && !prev_imem) || (cpu_clock && !prev_dmem)) order_err++;
    prev_imem = imem_clock;
    prev_dmem = dmem_clock;
    if (cpu_clock) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    run = 1'b0;
    step = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    clr_counts();
  endtask

  initial begin
    clr_counts();
    do_reset();
    chk("reset_running", {31'b0, running}, 32'd0);
    chk("reset_clocks", {29'b0, imem_clock, dmem_clock, cpu_clock}, 32'd0);
    chk("reset_bp_hit", {31'b0, bp_hit}, 32'd0);
    chk("reset_count", instr_count, 32'd0);

    // Free run for 40 cycles
    run = 1'b1;
    repeat (40) tick();
    chk("run40_imem", ic, 10);
    chk("run40_dmem", dc, 10);
    chk("run40_cpu", cc, 10);
    chk("run40_overlap", overlap, 0);
    chk("run40_order", order_err, 0);
    chk("run40_count", instr_count, 32'd10);
    run = 1'b0;
    tick();
    chk("run40_halted", {31'b0, running}, 32'd0);
    chk("run40_count_hold", instr_count, 32'd10);

    // Single step, second pulse during the instruction ignored
    do_reset();
    repeat (4) tick();
    step = 1'b1;
    tick();
    chk("step_first_imem", {31'b0, imem_clock}, 32'd1);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (8) tick();
    chk("step_count", instr_count, 32'd1);
    chk("step_running_cycles", rc, 4);
    chk("step_cpu_pulses", cc, 1);

    // Breakpoint at 0xC
    do_reset();
    pc = 32'h0;
    bp_en = 1'b1;
    bp_addr = 32'h0000000C;
    run = 1'b1;
    tick();
    for (int i = 0; i < 40 && running; i++) tick();
    run = 1'b0;
    chk("bp_halted", {31'b0, running}, 32'd0);
    chk("bp_hit_set", {31'b0, bp_hit}, 32'd1);
    chk("bp_count", instr_count, 32'd3);
    chk("bp_pc", pc, 32'hC);
    repeat (3) tick();
    chk("bp_still_halted", {31'b0, running}, 32'd0);
    chk("bp_hit_sticky", {31'b0, bp_hit}, 32'd1);
    run = 1'b1;
    tick();
    chk("resume_running", {31'b0, running}, 32'd1);
    chk("resume_bp_clear", {31'b0, bp_hit}, 32'd0);
    chk("resume_imem", {31'b0, imem_clock}, 32'd1);
    repeat (3) tick();
    chk("resume_count", instr_count, 32'd4);
    chk("resume_pc", pc, 32'h10);
    repeat (4) tick();
    chk("resume_continue", instr_count, 32'd5);
    chk("resume_no_rehit", {31'b0, bp_hit}, 32'd0);
    run = 1'b0;
    for (int i = 0; i < 10 && running; i++) tick();
    chk("resume_stopped", {31'b0, running}, 32'd0);
    bp_en = 1'b0;

    // run and step together, then drop run in phase 1
    do_reset();
    run = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (5) tick();
    chk("both_ph1_dmem", {31'b0, dmem_clock}, 32'd1);
    chk("both_ph1_count", instr_count, 32'd1);
    run = 1'b0;
    tick();
    chk("drop_cpu_pulse", {31'b0, cpu_clock}, 32'd1);
    chk("drop_count", instr_count, 32'd2);
    tick();
    chk("drop_ph3_running", {31'b0, running}, 32'd1);
    tick();
    chk("drop_halted", {31'b0, running}, 32'd0);
    chk("drop_final_count", instr_count, 32'd2);

    // Async reset while cpu_clock is high
    do_reset();
    run = 1'b1;
    repeat (3) tick();
    chk("pre_reset_cpu", {31'b0, cpu_clock}, 32'd1);
    resetn = 1'b0;
    run = 1'b0;
    #1;
    chk("async_cpu_low", {31'b0, cpu_clock}, 32'd0);
    chk("async_count_zero", instr_count, 32'd0);
    chk("async_running_low", {31'b0, running}, 32'd0);
    tick();
    resetn = 1'b1;
    clr_counts();
    repeat (8) tick();
    chk("post_reset_no_pulses", ic + dc + cc, 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    run = 1'b1;
    repeat (68) tick();
    run = 1'b0;
    tick();
    chk("wrap_count4", {28'b0, instr_count4}, 32'd1);
    chk("wrap_count32", instr_count, 32'd17);
    chk("wrap_halted", {31'b0, running4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
